// File: rtl/sram_mem_responder_if.sv
// -----------------------------------------------------------------------------
// sram_mem_responder_if
//   MEM-stage data-memory handshake between the pipeline (master) and the
//   SRAM responder (slave).
//   mem_r_en / mem_w_en : read / write request, held by the master until ready
//   address             : CPU byte address, word-aligned
//   wdata               : 32-bit write data
//   rdata               : 32-bit read data, valid in the ready cycle
//   ready               : 1 = idle or finishing, 0 = freeze the pipeline
// -----------------------------------------------------------------------------
interface sram_mem_responder_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output mem_r_en, mem_w_en, address, wdata,
    input  rdata, ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/sram_mem_responder.sv
// -----------------------------------------------------------------------------
// sram_mem_responder
//   Responder side of the MEM-stage data-memory interface. Each 32-bit read or
//   write is run as two 16-bit transfers (LOW halfword, then HIGH halfword) on
//   an external asynchronous SRAM. ready stays low while a transfer is in
//   flight so the top level can freeze the pipeline with ~ready.
//
// Ports
//   clk        pipeline clock
//   rst        asynchronous reset, active-low
//   mem        sram_mem_responder_if.slave (requests, wdata, rdata, ready)
//   sram_addr  SRAM halfword address
//   sram_dq    SRAM bidirectional data bus
//   sram_we_n  SRAM write enable, active-low
//   sram_oe_n  SRAM output enable, active-low
//
// Optional feature
//   SRAM_LAST_READ_CACHE_EN : one-entry last-read cache {valid, tag, data}.
//   A read hit in IDLE completes in the same cycle without touching the SRAM.
// -----------------------------------------------------------------------------
module sram_mem_responder #(
  parameter int          SRAM_AW     = 18,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_mem_responder_if.slave    mem,
  output logic [SRAM_AW-1:0]     sram_addr,
  inout  wire  [15:0]            sram_dq,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] base_q, base_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [15:0]        lo_q, lo_d;

  logic [31:0]        offset;
  logic [SRAM_AW-1:0] req_base;
  logic               req;
  logic               busy;
  logic               phase_last;
  logic               we_act;
  logic [15:0]        dq_out;
  logic               cache_hit;
  logic [31:0]        hit_data;

  // Byte offset from the SRAM window, converted to a halfword index; upper
  // bits beyond SRAM_AW are dropped so the window wraps.
  assign offset     = mem.address - BASE_ADDR;
  assign req_base   = offset[SRAM_AW:1];
  assign req        = mem.mem_r_en | mem.mem_w_en;
  assign busy       = (state_q == S_LOW) | (state_q == S_HIGH);
  assign phase_last = (cnt_q == LAST_CNT);

`ifdef SRAM_LAST_READ_CACHE_EN
  logic        cvld_q, cvld_d;
  logic [31:0] ctag_q, ctag_d;
  logic [31:0] cdata_q, cdata_d;

  // A write request (alone or together with a read) always goes to the SRAM.
  assign cache_hit = (state_q == S_IDLE) & mem.mem_r_en & ~mem.mem_w_en &
                     cvld_q & (ctag_q == mem.address);
  assign hit_data  = cdata_q;

  always_comb begin
    cvld_d  = cvld_q;
    ctag_d  = ctag_q;
    cdata_d = cdata_q;
    if (state_q == S_DONE) begin
      if (!wr_q) begin
        cvld_d  = 1'b1;
        ctag_d  = addr_q;
        cdata_d = rdata_q;
      end else if (cvld_q && (ctag_q == addr_q)) begin
        cdata_d = wdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cvld_q <= 1'b0;
    else      cvld_q <= cvld_d;
  end

  always_ff @(posedge clk) begin
    ctag_q  <= ctag_d;
    cdata_q <= cdata_d;
  end
`else
  assign cache_hit = 1'b0;
  assign hit_data  = 32'd0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    base_d  = base_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (cache_hit) begin
          // Keep rdata stable at the hit value after the hit cycle.
          rdata_d = hit_data;
        end else if (req) begin
          state_d = S_LOW;
          cnt_d   = 4'd0;
          wr_d    = mem.mem_w_en;
          base_d  = req_base;
          addr_d  = mem.address;
          wdata_d = mem.wdata;
        end
      end
      S_LOW: begin
        if (phase_last) begin
          state_d = S_HIGH;
          cnt_d   = 4'd0;
          // Low half is parked so rdata only changes when the whole word lands.
          if (!wr_q) lo_d = sram_dq;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (phase_last) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
          if (!wr_q) rdata_d = {sram_dq, lo_q};
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q  <= base_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    lo_q    <= lo_d;
  end

  // we_n rises in the last cycle of each phase while data is still driven,
  // giving the SRAM data hold; a one-cycle phase keeps we_n low throughout.
  assign we_act    = busy & wr_q & ((LAST_CNT == 4'd0) | ~phase_last);
  assign sram_we_n = ~we_act;
  assign sram_oe_n = ~(busy & ~wr_q);

  always_comb begin
    sram_addr = '0;
    if (state_q == S_LOW)       sram_addr = base_q;
    else if (state_q == S_HIGH) sram_addr = {base_q[SRAM_AW-1:1], 1'b1};
  end

  assign dq_out  = (state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  assign sram_dq = (busy & wr_q) ? dq_out : 16'hzzzz;

  assign mem.ready = (state_q == S_DONE) | ((state_q == S_IDLE) & ~req) | cache_hit;
  assign mem.rdata = cache_hit ? hit_data : rdata_q;

endmodule

// File: tb/tb_sram_mem_responder.sv
module tb_sram_mem_responder;

  logic        clk;
  logic        rst;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        probe_en;
  logic [15:0] sram [16];

  int passed;
  int failed;
  int total;

  sram_mem_responder_if mem_if ();

  sram_mem_responder #(
    .SRAM_AW    (18),
    .BASE_ADDR  (32'd1024),
    .WAIT_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem      (mem_if),
    .sram_addr(sram_addr),
    .sram_dq  (sram_dq),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM model: drives the bus while oe_n is low, latches while we_n is
  // low. probe_en puts a known pattern on the bus to show the DUT releases it.
  assign sram_dq = (!sram_oe_n) ? sram[sram_addr[3:0]] :
                   (probe_en ? 16'hA5A5 : 16'hzzzz);

  always @(posedge clk) begin
    if (!sram_we_n) sram[sram_addr[3:0]] <= sram_dq;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request starting just after a rising edge and holds it until
  // ready is seen; returns read data and per-cycle observations.
  task automatic do_req(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdat,
                        output int zeros, output int we_low, output int oe_low,
                        output logic [17:0] a1, output logic [17:0] a3,
                        output logic [15:0] d1, output logic [15:0] d3);
    int  cyc;
    logic done;
    mem_if.mem_w_en = wr;
    mem_if.mem_r_en = rd;
    mem_if.address  = a;
    mem_if.wdata    = d;
    zeros = 0; we_low = 0; oe_low = 0; cyc = 0; done = 1'b0;
    rdat = 32'd0; a1 = '0; a3 = '0; d1 = '0; d3 = '0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (cyc == 1) begin a1 = sram_addr; d1 = sram_dq; end
      if (cyc == 3) begin a3 = sram_addr; d3 = sram_dq; end
      if (mem_if.ready) begin
        rdat = mem_if.rdata;
        done = 1'b1;
      end else begin
        zeros++;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    mem_if.mem_w_en = 1'b0;
    mem_if.mem_r_en = 1'b0;
    check("req_completes", 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] rdat;
    int          zeros, we_low, oe_low;
    logic [17:0] a1, a3;
    logic [15:0] d1, d3;
    int          exp_zeros_hit;

    passed = 0; failed = 0; total = 0;
    probe_en = 1'b0;
    rst = 1'b0;
    mem_if.mem_r_en = 1'b0;
    mem_if.mem_w_en = 1'b0;
    mem_if.address  = 32'd0;
    mem_if.wdata    = 32'd0;
`ifdef SRAM_LAST_READ_CACHE_EN
    exp_zeros_hit = 0;
`else
    exp_zeros_hit = 5;
`endif

    // Reset values
    #3;
    check("rst_ready", 32'(mem_if.ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_rdata", mem_if.rdata, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Idle for 10 cycles: bus released, strobes inactive
    probe_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(mem_if.ready), 32'd1);
      check("idle_we_n", 32'(sram_we_n), 32'd1);
      check("idle_oe_n", 32'(sram_oe_n), 32'd1);
      check("idle_dq_released", 32'(sram_dq), 32'h0000A5A5);
    end
    @(posedge clk); #1;
    probe_en = 1'b0;

    // Write 0xDEADBEEF to 1024: request cycle plus 4 busy cycles, then ready
    do_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, rdat, zeros, we_low, oe_low, a1, a3, d1, d3);
    check("w1_ready_low_cycles", 32'(zeros), 32'd5);
    check("w1_we_low_cycles", 32'(we_low), 32'd2);
    check("w1_oe_low_cycles", 32'(oe_low), 32'd0);
    check("w1_low_addr", 32'(a1), 32'd0);
    check("w1_high_addr", 32'(a3), 32'd1);
    check("w1_low_dq", 32'(d1), 32'h0000BEEF);
    check("w1_high_dq", 32'(d3), 32'h0000DEAD);
    check("w1_sram0", 32'(sram[0]), 32'h0000BEEF);
    check("w1_sram1", 32'(sram[1]), 32'h0000DEAD);
    check("w1_rdata_untouched", rdat, 32'd0);

    // Read 1024 back
    do_req(1'b0, 1'b1, 32'd1024, 32'd0, rdat, zeros, we_low, oe_low, a1, a3, d1, d3);
    check("r1_ready_low_cycles", 32'(zeros), 32'd5);
    check("r1_oe_low_cycles", 32'(oe_low), 32'd4);
    check("r1_we_low_cycles", 32'(we_low), 32'd0);
    check("r1_rdata", rdat, 32'hDEADBEEF);

    // Back-to-back write then read at 1028
    do_req(1'b1, 1'b0, 32'd1028, 32'h12345678, rdat, zeros, we_low, oe_low, a1, a3, d1, d3);
    check("w2_low_addr", 32'(a1), 32'd2);
    check("w2_high_addr", 32'(a3), 32'd3);
    do_req(1'b0, 1'b1, 32'd1028, 32'd0, rdat, zeros, we_low, oe_low, a1, a3, d1, d3);
    check("w2_sram2", 32'(sram[2]), 32'h00005678);
    check("w2_sram3", 32'(sram[3]), 32'h00001234);
    check("r2_rdata", rdat, 32'h12345678);

    // Both requests set: write wins, rdata keeps the last read value
    do_req(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, rdat, zeros, we_low, oe_low, a1, a3, d1, d3);
    check("both_we_low_cycles", 32'(we_low), 32'd2);
    check("both_oe_low_cycles", 32'(oe_low), 32'd0);
    check("both_sram4", 32'(sram[4]), 32'h0000F00D);
    check("both_sram5", 32'(sram[5]), 32'h0000CAFE);
    check("both_rdata_held", rdat, 32'h12345678);

    // Address wraps: 1028 + 2^19 lands on halfword 2 again
    do_req(1'b0, 1'b1, 32'h00080404, 32'd0, rdat, zeros, we_low, oe_low, a1, a3, d1, d3);
    check("wrap_low_addr", 32'(a1), 32'd2);
    check("wrap_rdata", rdat, 32'h12345678);

    // Read 1024 twice; the second is a cache hit when the cache is built in
    do_req(1'b0, 1'b1, 32'd1024, 32'd0, rdat, zeros, we_low, oe_low, a1, a3, d1, d3);
    check("rr1_ready_low_cycles", 32'(zeros), 32'd5);
    check("rr1_rdata", rdat, 32'hDEADBEEF);
    do_req(1'b0, 1'b1, 32'd1024, 32'd0, rdat, zeros, we_low, oe_low, a1, a3, d1, d3);
    check("rr2_ready_low_cycles", 32'(zeros), 32'(exp_zeros_hit));
    check("rr2_rdata", rdat, 32'hDEADBEEF);

    // Write new data to 1024, read returns it
    do_req(1'b1, 1'b0, 32'd1024, 32'h0BADCAFE, rdat, zeros, we_low, oe_low, a1, a3, d1, d3);
    do_req(1'b0, 1'b1, 32'd1024, 32'd0, rdat, zeros, we_low, oe_low, a1, a3, d1, d3);
    check("wr_upd_ready_low_cycles", 32'(zeros), 32'(exp_zeros_hit));
    check("wr_upd_rdata", rdat, 32'h0BADCAFE);

    // Reset asserted in cycle 2 of a write
    mem_if.mem_w_en = 1'b1;
    mem_if.address  = 32'd1036;
    mem_if.wdata    = 32'h11112222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_we_active", 32'(sram_we_n), 32'd1);
    check("mid_addr_low", 32'(sram_addr), 32'd6);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_we_n", 32'(sram_we_n), 32'd1);
    check("mrst_oe_n", 32'(sram_oe_n), 32'd1);
    check("mrst_addr", 32'(sram_addr), 32'd0);
    check("mrst_rdata", mem_if.rdata, 32'd0);
    check("mrst_ready_req_held", 32'(mem_if.ready), 32'd0);
    mem_if.mem_w_en = 1'b0;
    #1;
    check("mrst_ready_no_req", 32'(mem_if.ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(mem_if.ready), 32'd1);
    @(posedge clk); #1;

    // After reset the cache is empty, so the read runs the full sequence
    do_req(1'b0, 1'b1, 32'd1024, 32'd0, rdat, zeros, we_low, oe_low, a1, a3, d1, d3);
    check("post_rst_ready_low_cycles", 32'(zeros), 32'd5);
    check("post_rst_oe_low_cycles", 32'(oe_low), 32'd4);
    check("post_rst_rdata", rdat, 32'h0BADCAFE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
